gate_sweep_ctrl: RTL and testbench

//   Sequencer that exhaustively exercises the AND->OR gate datapath, where y = (a & b) | c.

---
 rtl/gate_sweep_ctrl_if.sv | 33 +++
 rtl/gate_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Handshake/observation bundle between gate_sweep_ctrl and its environment.
//   start             sweep request from the host/button side
//   op_a/op_b/op_c    registered operands driven to the AND->OR gate pair
//   and_obs/y_obs     observed gate outputs fed back to the sequencer
//   busy/done/pass    sweep status
//   err_count         mismatch total, ERR_W bits, saturating
//   vec_idx           current/last operand vector {a,b,c}
// Modports: slave = the sequencer, master = host plus gate datapath.
interface gate_sweep_ctrl_if #(
   parameter int unsigned ERR_W = 4
);
   logic             start;
   logic             op_a;
   logic             op_b;
   logic             op_c;
   logic             and_obs;
   logic             y_obs;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [2:0]       vec_idx;

   modport slave (
      input  start, and_obs, y_obs,
      output op_a, op_b, op_c, busy, done, pass, err_count, vec_idx
   );

   modport master (
      output start, and_obs, y_obs,
      input  op_a, op_b, op_c, busy, done, pass, err_count, vec_idx
   );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Sequencer that sweeps all 8 {a,b,c} vectors through the y = (a & b) | c gate pair, holds
// each vector SETTLE_CYCLES cycles, samples and_obs/y_obs for one cycle, and counts
// mismatches against the ideal truth table.
// Ports:
//   clock    system clock, rising edge
//   reset_n  synchronous active-low reset; aborts any sweep in progress
//   bus      gate_sweep_ctrl_if.slave (start in, operands out, observations in, status out)
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling, legal 1..15
//   ERR_W          mismatch counter width; the counter saturates at all-ones
// Build option:
//   STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep and the failing vector is
//                    left on vec_idx/op_* for debug; otherwise all 8 vectors are always swept.
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 4
) (
   input logic               clock,
   input logic               reset_n,
   gate_sweep_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   localparam int unsigned      CntW       = 4;
   localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ErrMax     = '1;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [2:0]       vec_q, vec_d;
   logic [2:0]       op_q, op_d;    // {a,b,c}
   logic [ERR_W-1:0] err_q, err_d;
   logic             busy_q, busy_d;
   logic             pass_q, pass_d;

   logic exp_and, exp_y, mismatch;

   always_comb begin
      exp_and  = vec_q[2] & vec_q[1];
      exp_y    = exp_and | vec_q[0];
      mismatch = (bus.and_obs != exp_and) || (bus.y_obs != exp_y);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      op_d    = op_q;
      err_d   = err_q;
      busy_d  = busy_q;
      pass_d  = pass_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StDrive;
               cnt_d   = '0;
               vec_d   = '0;
               op_d    = '0;
               err_d   = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         StDrive: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == SettleLast) begin
               state_d = StSample;
            end
         end

         StSample: begin
            if (mismatch && (err_q != ErrMax)) begin
               err_d = err_q + ERR_W'(1);
            end
`ifdef STOP_ON_FAIL_EN
            if (mismatch || (vec_q == 3'd7)) begin
`else
            if (vec_q == 3'd7) begin
`endif
               state_d = StDone;
               // Account for this cycle's mismatch, not just the accumulated total.
               pass_d  = (err_q == '0) && !mismatch;
            end else begin
               state_d = StDrive;
               vec_d   = vec_q + 3'd1;
               op_d    = vec_q + 3'd1;
               cnt_d   = '0;
            end
         end

         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         vec_q   <= '0;
         op_q    <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         op_q    <= op_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.op_a      = op_q[2];
   assign bus.op_b      = op_q[1];
   assign bus.op_c      = op_q[0];
   assign bus.vec_idx   = vec_q;
   assign bus.err_count = err_q;
   assign bus.busy      = busy_q;
   assign bus.pass      = pass_q;
   assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: dut0 (SETTLE_CYCLES=2, ERR_W=4) and dut1 (SETTLE_CYCLES=1,
// ERR_W=2). Each sweep's expected result is pushed when start is driven and popped on done.
module tb_gate_sweep_ctrl;

   localparam int unsigned S0 = 2;
   localparam int unsigned E0 = 4;
   localparam int unsigned S1 = 1;
   localparam int unsigned E1 = 2;
   localparam int          Hold = 60;

   typedef struct {
      int err;
      int pass;
      int vec;
      int lat;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int fault0 = 0;   // 0 ideal, 1 y stuck at 0, 2 and stuck at 1
   int fault1 = 0;

   gate_sweep_ctrl_if #(.ERR_W(E0)) bus0 ();
   gate_sweep_ctrl_if #(.ERR_W(E1)) bus1 ();

   gate_sweep_ctrl #(.SETTLE_CYCLES(S0), .ERR_W(E0)) dut0 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   gate_sweep_ctrl #(.SETTLE_CYCLES(S1), .ERR_W(E1)) dut1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   function automatic logic gate_and(int f, logic a, logic b);
      return (f == 2) ? 1'b1 : (a & b);
   endfunction

   function automatic logic gate_y(int f, logic and_v, logic c);
      return (f == 1) ? 1'b0 : (and_v | c);
   endfunction

   assign bus0.and_obs = gate_and(fault0, bus0.op_a, bus0.op_b);
   assign bus0.y_obs   = gate_y(fault0, bus0.and_obs, bus0.op_c);
   assign bus1.and_obs = gate_and(fault1, bus1.op_a, bus1.op_b);
   assign bus1.y_obs   = gate_y(fault1, bus1.and_obs, bus1.op_c);

   // Truth-table model of one sweep against a given faulty gate.
   function automatic exp_t model(int f, int s, int errw);
      exp_t e;
      int   n   = 0;
      int   cap = (1 << errw) - 1;
      int   last = 7;
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vb = 3'(v);
         logic ea = vb[2] & vb[1];
         logic ey = ea | vb[0];
         logic oa = gate_and(f, vb[2], vb[1]);
         logic oy = gate_y(f, oa, vb[0]);
         if ((oa != ea) || (oy != ey)) begin
            n++;
`ifdef STOP_ON_FAIL_EN
            last = v;
            break;
`endif
         end
      end
      e.err  = (n > cap) ? cap : n;
      e.pass = (n == 0) ? 1 : 0;
      e.vec  = last;
      e.lat  = (last + 1) * (s + 1);
      return e;
   endfunction

   exp_t q0[$];
   exp_t q1[$];
   int   total  = 0;
   int   passed = 0;
   int   cyc    = 0;

   always @(posedge clock) cyc++;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // dut0 monitor
   logic busy0_prev = 1'b0;
   int   rise0      = 0;
   always @(negedge clock) begin
      exp_t e;
      if ((bus0.busy === 1'b1) && !busy0_prev) begin
         rise0 = cyc;
         chk("dut0 err cleared at start", 32'(bus0.err_count), 0);
         chk("dut0 vec zero at start", 32'(bus0.vec_idx), 0);
      end
      busy0_prev = (bus0.busy === 1'b1);
      if (bus0.done === 1'b1) begin
         if (q0.size() == 0) begin
            chk("dut0 unexpected done", 32'(q0.size()), 1);
         end else begin
            e = q0.pop_front();
            chk("dut0 err_count", 32'(bus0.err_count), e.err);
            chk("dut0 pass", 32'(bus0.pass), e.pass);
            chk("dut0 vec_idx", 32'(bus0.vec_idx), e.vec);
            chk("dut0 ops", 32'({bus0.op_a, bus0.op_b, bus0.op_c}), e.vec);
            chk("dut0 done latency", 32'(cyc - rise0), e.lat);
            chk("dut0 busy in done", 32'(bus0.busy), 1);
         end
      end
   end

   // dut1 monitor
   logic busy1_prev = 1'b0;
   int   rise1      = 0;
   int   last_done1 = -1;
   logic hold1      = 1'b0;
   always @(negedge clock) begin
      exp_t e;
      if ((bus1.busy === 1'b1) && !busy1_prev) begin
         rise1 = cyc;
         chk("dut1 err cleared at start", 32'(bus1.err_count), 0);
      end
      busy1_prev = (bus1.busy === 1'b1);
      if (bus1.done === 1'b1) begin
         if (q1.size() == 0) begin
            chk("dut1 unexpected done", 32'(q1.size()), 1);
         end else begin
            e = q1.pop_front();
            chk("dut1 err_count", 32'(bus1.err_count), e.err);
            chk("dut1 pass", 32'(bus1.pass), e.pass);
            chk("dut1 vec_idx", 32'(bus1.vec_idx), e.vec);
            chk("dut1 done latency", 32'(cyc - rise1), e.lat);
            // Back-to-back sweeps: sweep cycles + DONE + one IDLE cycle.
            if (hold1 && (last_done1 >= 0)) begin
               chk("dut1 done spacing", 32'(cyc - last_done1), 8 * (S1 + 1) + 2);
            end
         end
         last_done1 = cyc;
      end
   end

   task automatic pulse0();
      @(negedge clock) bus0.start = 1'b1;
      @(negedge clock) bus0.start = 1'b0;
   endtask

   task automatic wait_q0(string tag);
      for (int i = 0; (i < 400) && (q0.size() != 0); i++) @(negedge clock);
      chk(tag, 32'(q0.size()), 0);
   endtask

   task automatic wait_q1(string tag);
      for (int i = 0; (i < 400) && (q1.size() != 0); i++) @(negedge clock);
      chk(tag, 32'(q1.size()), 0);
   endtask

   task automatic chk_zero0(string tag);
      chk(tag, 32'({bus0.op_a, bus0.op_b, bus0.op_c, bus0.busy, bus0.done, bus0.pass,
                    bus0.err_count, bus0.vec_idx}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      repeat (2) @(negedge clock);
      chk_zero0("dut0 reset outputs");
      chk("dut1 reset outputs", 32'({bus1.op_a, bus1.op_b, bus1.op_c, bus1.busy, bus1.done,
                                     bus1.pass, bus1.err_count, bus1.vec_idx}), 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Ideal gates, single start pulse
      fault0 = 0;
      q0.push_back(model(0, S0, E0));
      pulse0();
      wait_q0("t1 sweep completes");
      @(negedge clock);
      chk("t1 busy low after done", 32'(bus0.busy), 0);
      repeat (3) @(negedge clock);
      chk("t1 vec holds", 32'(bus0.vec_idx), 7);
      chk("t1 pass holds", 32'(bus0.pass), 1);

      // y stuck at 0
      fault0 = 1;
      q0.push_back(model(1, S0, E0));
      pulse0();
      wait_q0("t2 sweep completes");
      repeat (2) @(negedge clock);
      fault0 = 0;

      // and stuck at 1 on the narrow counter
      fault1 = 2;
      q1.push_back(model(2, S1, E1));
      @(negedge clock) bus1.start = 1'b1;
      @(negedge clock) bus1.start = 1'b0;
      wait_q1("t3 sweep completes");
      repeat (2) @(negedge clock);
      fault1 = 0;

      // Restart attempt mid-sweep is ignored
      q0.push_back(model(0, S0, E0));
      pulse0();
      repeat (4) @(negedge clock);
      pulse0();
      wait_q0("t4 sweep completes");
      repeat (30) @(negedge clock);
      chk("t4 no extra done", 32'(q0.size()), 0);

      // Reset mid-sweep at vector 4
      q0.push_back(model(0, S0, E0));
      pulse0();
      for (int i = 0; (i < 100) && (bus0.vec_idx !== 3'd4); i++) @(negedge clock);
      chk("t5 reached vector 4", 32'(bus0.vec_idx), 4);
      reset_n = 1'b0;
      q0.delete();
      @(negedge clock);
      reset_n = 1'b1;
      chk_zero0("t5 outputs after reset");
      q0.push_back(model(0, S0, E0));
      pulse0();
      wait_q0("t5 clean sweep completes");
      repeat (2) @(negedge clock);

      // start held high on dut1
      fault1 = 0;
      last_done1 = -1;
      hold1      = 1'b1;
      for (int n = 0; n < (Hold - 1) / (8 * (S1 + 1) + 2) + 1; n++) begin
         q1.push_back(model(0, S1, E1));
      end
      @(negedge clock) bus1.start = 1'b1;
      repeat (Hold) @(negedge clock);
      bus1.start = 1'b0;
      wait_q1("t6 held sweeps complete");
      hold1 = 1'b0;
      repeat (25) @(negedge clock);
      chk("t6 no extra sweep", 32'(bus1.busy), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
